// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: FSM state codes and default width.
package timer_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/up_counter_en.sv
// Generic WIDTH-bit up counter; sync clear, sync zero-load, count enable.
// Priority: clear > zero_i > en_i. Output is the state register itself.
module up_counter_en
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             zero_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (zero_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer: start/stop FSM over up_counter_en, one-shot or
// periodic tick at the programmed limit, with registered busy/done/err status.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] count
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_zero;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_val;

  up_counter_en #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .clear   (clear),
    .zero_i  (cnt_zero),
    .en_i    (cnt_en),
    .count_o (cnt_val)
  );

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;
    err_d      = 1'b0;
    cnt_zero   = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_zero = 1'b1;
        if (!stop && start) begin
          if (limit != '0) begin
            limit_d    = limit;
            periodic_d = periodic;
            state_d    = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        // stop is checked first so an abort on the terminal cycle never ticks
        if (stop) begin
          state_d  = ST_IDLE;
          cnt_zero = 1'b1;
        end else if (cnt_val == limit_q) begin
          tick_d = 1'b1;
          if (periodic_q) begin
            cnt_zero = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_DONE: begin
        if (stop) begin
          state_d  = ST_IDLE;
          cnt_zero = 1'b1;
        end else if (start) begin
          if (limit != '0) begin
            limit_d    = limit;
            periodic_d = periodic;
            cnt_zero   = 1'b1;
            state_d    = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_zero = 1'b1;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      busy_q     <= busy_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy  = busy_q;
  assign tick  = tick_q;
  assign done  = done_q;
  assign err   = err_q;
  assign count = cnt_val;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Bench for interval_timer_ctrl: directed vector table, corner-case sequences,
// and random traffic against an elapsed-edges arithmetic reference model.
module tb_interval_timer_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         periodic = 1'b0;
  logic [W-1:0] limit = '0;
  logic         busy, tick, done, err;
  logic [W-1:0] count;

  always #5 clk = ~clk;

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .clear    (clear),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .limit    (limit),
    .busy     (busy),
    .tick     (tick),
    .done     (done),
    .err      (err),
    .count    (count)
  );

  int nerr = 0;
  int nchk = 0;

  // Model: mode 0 idle / 1 running / 2 finished; k = edges since the start edge.
  int m_mode = 0;
  int m_k    = 0;
  int m_L    = 0;
  bit m_per  = 1'b0;
  int e_busy, e_tick, e_done, e_err, e_count;

  typedef struct {
    bit c, s, p, pr;
    int lim;
    int busy, tick, done, err, cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit c, bit s, bit p, bit pr, int lim,
                              int b, int t, int d, int e, int cnt);
    vec_t v;
    v.c = c; v.s = s; v.p = p; v.pr = pr; v.lim = lim;
    v.busy = b; v.tick = t; v.done = d; v.err = e; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit c, input bit s, input bit p, input bit pr, input int lim);
    e_tick = 0;
    e_err  = 0;
    if (c) begin
      m_mode = 0; m_k = 0; m_L = 0; m_per = 1'b0;
    end else if (p) begin
      m_mode = 0; m_k = 0;
    end else if (m_mode == 1) begin
      m_k++;
      if (m_per) begin
        if (m_k % (m_L + 1) == 0) e_tick = 1;
      end else if (m_k == m_L + 1) begin
        e_tick = 1;
        m_mode = 2;
      end
    end else if (s) begin
      if (lim != 0) begin
        m_mode = 1; m_k = 0; m_L = lim; m_per = pr;
      end else begin
        e_err = 1;
      end
    end
    e_busy  = (m_mode == 1);
    e_done  = (m_mode == 2);
    e_count = (m_mode == 1) ? (m_k % (m_L + 1)) : (m_mode == 2) ? m_L : 0;
  endtask

  task automatic drive(input bit c, input bit s, input bit p, input bit pr, input int lim);
    clear = c; start = s; stop = p; periodic = pr; limit = W'(lim);
    @(posedge clk);
    model_step(c, s, p, pr, lim);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_busy"},  int'(busy),  e_busy);
    chk({tag, "_tick"},  int'(tick),  e_tick);
    chk({tag, "_done"},  int'(done),  e_done);
    chk({tag, "_err"},   int'(err),   e_err);
    chk({tag, "_count"}, int'(count), e_count);
  endtask

  task automatic cyc(input string tag, input bit c, input bit s, input bit p, input bit pr, input int lim);
    drive(c, s, p, pr, lim);
    check_model(tag);
  endtask

  initial begin
    int nt, first_at, cnt_at;

    // c s p pr lim | busy tick done err cnt
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,3, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,1));
    tbl.push_back(mk(0,1,0,1,7, 1,0,0,0,2));  // start in RUN ignored
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,3));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,3));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,3));
    tbl.push_back(mk(0,0,0,0,9, 0,0,1,0,3));
    tbl.push_back(mk(0,1,1,0,5, 0,0,0,0,0));  // stop beats start in DONE
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,1,0));  // limit 0 -> err
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,5, 0,0,0,0,0));  // start+stop in IDLE
    tbl.push_back(mk(0,1,0,1,1, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,0,0));  // stop on terminal cycle

    foreach (tbl[i]) begin
      drive(tbl[i].c, tbl[i].s, tbl[i].p, tbl[i].pr, tbl[i].lim);
      chk($sformatf("vec%0d_busy", i),  int'(busy),  tbl[i].busy);
      chk($sformatf("vec%0d_tick", i),  int'(tick),  tbl[i].tick);
      chk($sformatf("vec%0d_done", i),  int'(done),  tbl[i].done);
      chk($sformatf("vec%0d_err", i),   int'(err),   tbl[i].err);
      chk($sformatf("vec%0d_count", i), int'(count), tbl[i].cnt);
    end

    // Clear held two cycles mid-RUN
    cyc("rst_start", 0, 1, 0, 1, 10);
    for (int i = 0; i < 3; i++) cyc("rst_run", 0, 0, 0, 0, 0);
    cyc("rst_c0", 1, 0, 0, 0, 0);
    cyc("rst_c1", 1, 0, 0, 0, 0);
    cyc("rst_after", 0, 0, 0, 0, 0);

    // Periodic limit 2: five ticks in 16 edges, then stop
    cyc("per_start", 0, 1, 0, 1, 2);
    nt = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc("per_run", 0, 0, 0, 0, 0);
      if (tick) nt++;
    end
    chk("per_ticks", nt, 5);
    cyc("per_stop", 0, 0, 1, 0, 0);

    // Max limit one-shot: tick on edge 16 with count 15
    cyc("max_start", 0, 1, 0, 0, 15);
    first_at = -1;
    cnt_at = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc("max_run", 0, 0, 0, 0, 0);
      if (tick && first_at < 0) begin
        first_at = i;
        cnt_at = int'(count);
      end
    end
    chk("max_tick_at", first_at, 16);
    chk("max_tick_cnt", cnt_at, 15);

    // Stop exactly when count == limit
    cyc("stp_start", 0, 1, 0, 0, 3);
    for (int i = 0; i < 3; i++) cyc("stp_run", 0, 0, 0, 0, 0);
    chk("stp_at_limit", int'(count), 3);
    cyc("stp_hit", 0, 0, 1, 0, 0);
    chk("stp_no_tick", int'(tick), 0);

    // Retrigger attempt during RUN leaves tick timing intact
    cyc("rtg_start", 0, 1, 0, 0, 4);
    cyc("rtg_run", 0, 0, 0, 0, 0);
    cyc("rtg_retrig", 0, 1, 0, 1, 1);
    first_at = -1;
    for (int i = 3; i <= 8; i++) begin
      cyc("rtg_run", 0, 0, 0, 0, 0);
      if (tick && first_at < 0) first_at = i;
    end
    chk("rtg_tick_at", first_at, 5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc("rnd",
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 24) == 0),
          1'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
